// File: rtl/melody_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------
// melody_sequencer : plays a ROM-stored song into the buzzer note/pitch
// Revision 1.0
// ------------------------------------------------------------------------
module melody_sequencer #(
    parameter int SIXTEENTH_CYCLES = 6_250_000,
    parameter int GAP_CYCLES       = 500_000,
    parameter int ADDR_W           = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [9:0]        rom_data,
    output logic [4:0]        note,
    output logic [1:0]        pitch,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] step_idx
);

    localparam int                  C_CNT_W     = $clog2(7 * SIXTEENTH_CYCLES);
    localparam logic [C_CNT_W-1:0]  C_GAP_CNT   = C_CNT_W'(GAP_CYCLES);
    localparam logic [ADDR_W-1:0]   C_ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_PLAY   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0]   step_idx_q, step_idx_d;
    logic [4:0]          note_q,     note_d;
    logic [1:0]          pitch_q,    pitch_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic [C_CNT_W-1:0]  cnt_q,      cnt_d;

    logic [2:0]          w_dur;
    logic [C_CNT_W-1:0]  w_load;

    assign w_dur  = rom_data[2:0];
    assign w_load = C_CNT_W'(int'(w_dur) * SIXTEENTH_CYCLES - 1);

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        step_idx_d = step_idx_q;
        note_d     = note_q;
        pitch_d    = pitch_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;

        if (stop) begin
            state_d = S_IDLE;
            note_d  = '0;
            pitch_d = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    note_d  = '0;
                    pitch_d = '0;
                    busy_d  = 1'b0;
                    if (start) begin
                        rom_addr_d = '0;
                        busy_d     = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    if (w_dur != 3'd0) begin
                        note_d     = rom_data[9:5];
                        pitch_d    = rom_data[4:3];
                        step_idx_d = rom_addr_q;
                        cnt_d      = w_load;
                        state_d    = S_PLAY;
                    end else if (loop_en && (rom_addr_q != '0)) begin
                        rom_addr_d = '0;
                        state_d    = S_FETCH;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_PLAY: begin
                    if (cnt_q == '0) begin
                        note_d  = '0;
                        pitch_d = '0;
                        if (rom_addr_q == C_ADDR_LAST) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            rom_addr_d = rom_addr_q + 1'b1;
                            state_d    = S_FETCH;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        // Counter reaches GAP_CYCLES-1 on this edge: articulation gap starts
                        if (cnt_q == C_GAP_CNT) begin
                            note_d  = '0;
                            pitch_d = '0;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            step_idx_q <= '0;
            note_q     <= '0;
            pitch_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            step_idx_q <= step_idx_d;
            note_q     <= note_d;
            pitch_q    <= pitch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign step_idx = step_idx_q;
    assign note     = note_q;
    assign pitch    = pitch_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_melody_sequencer : self-checking bench with a song-timeline model
// Revision 1.0
// ------------------------------------------------------------------------
module tb_melody_sequencer;

    localparam int S  = 10;
    localparam int G  = 2;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [AW-1:0] rom_addr;
    logic [9:0]    rom_data;
    logic [4:0]    note;
    logic [1:0]    pitch;
    logic          busy;
    logic          done;
    logic [AW-1:0] step_idx;

    logic [9:0]    rom [0:7];

    int n_checks = 0;
    int n_fail   = 0;

    melody_sequencer #(
        .SIXTEENTH_CYCLES (S),
        .GAP_CYCLES       (G),
        .ADDR_W           (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .note     (note),
        .pitch    (pitch),
        .busy     (busy),
        .done     (done),
        .step_idx (step_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data for rom_addr appears one clock later
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: position in time since the current step's fetch began
    logic          m_valid = 1'b0;
    logic          m_busy  = 1'b0;
    logic          m_done  = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [AW-1:0] m_step  = '0;
    logic [9:0]    m_word  = '0;
    int            m_t     = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_addr  = '0;
            m_step  = '0;
            m_word  = '0;
            m_t     = 0;
        end else if (stop) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1;
                m_addr = '0;
                m_t    = 0;
            end
        end else begin
            m_t++;
            if (m_t == 2) begin
                m_word = rom[m_addr];
                if (m_word[2:0] == 3'd0) begin
                    if (loop_en && m_addr != 0) begin
                        m_addr = '0;
                        m_t    = 0;
                    end else begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end else begin
                    m_step = m_addr;
                end
            end else if (m_t > 2 && m_t == int'(m_word[2:0]) * S + 2) begin
                if (m_addr == AW'(7)) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_addr = m_addr + 1'b1;
                    m_t    = 0;
                end
            end
        end
    end

    int   e_len;
    logic e_aud;
    always @(negedge clk) begin
        if (m_valid) begin
            e_len = int'(m_word[2:0]) * S;
            e_aud = m_busy && (m_t >= 2) && (m_t < e_len - G + 2);
            check("note",     note,     e_aud ? int'(m_word[9:5]) : 0);
            check("pitch",    pitch,    e_aud ? int'(m_word[4:3]) : 0);
            check("busy",     busy,     m_busy);
            check("done",     done,     m_done);
            check("rom_addr", rom_addr, m_addr);
            check("step_idx", step_idx, m_step);
        end
    end

    task automatic watch(input int n, output int aud, output int dn,
                         output int first_aud, output int first_done);
        aud = 0; dn = 0; first_aud = -1; first_done = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (note != 0 && pitch != 0) begin
                aud++;
                if (first_aud < 0) first_aud = i;
            end
            if (done) begin
                dn++;
                if (first_done < 0) first_done = i;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    int aud, dn, fa, fd, aud_sum, dn_sum;

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        for (int i = 0; i < 8; i++) rom[i] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset then idle
        watch(20, aud, dn, fa, fd);
        check("idle_aud", aud, 0);
        check("idle_done", dn, 0);
        check("idle_busy", busy, 0);
        check("idle_addr", rom_addr, 0);

        // Single note {6,1,2} then end marker
        rom[0] = {5'd6, 2'd1, 3'd2};
        rom[1] = 10'd0;
        pulse_start();
        watch(30, aud, dn, fa, fd);
        check("single_aud", aud, 18);
        check("single_first", fa, 2);
        check("single_done_at", fd, 24);
        check("single_done_cnt", dn, 1);
        check("single_busy_after", busy, 0);

        // Sequence with a rest
        rom[0] = {5'd1, 2'd1, 3'd1};
        rom[1] = {5'd0, 2'd1, 3'd3};
        rom[2] = {5'd9, 2'd2, 3'd1};
        rom[3] = 10'd0;
        pulse_start();
        watch(62, aud, dn, fa, fd);
        check("seq_aud", aud, 16);
        check("seq_done_at", fd, 58);
        check("seq_step_idx", step_idx, 2);
        check("seq_addr", rom_addr, 3);

        // Loop, then drop loop_en
        rom[0] = {5'd6, 2'd1, 3'd2};
        rom[1] = 10'd0;
        loop_en = 1'b1;
        pulse_start();
        watch(72, aud, dn, fa, fd);
        check("loop_aud", aud, 54);
        check("loop_done_cnt", dn, 0);
        loop_en = 1'b0;
        watch(30, aud, dn, fa, fd);
        check("loopend_aud", aud, 18);
        check("loopend_first", fa, 2);
        check("loopend_done_at", fd, 24);

        // Stop mid-note
        pulse_start();
        watch(6, aud, dn, fa, fd);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_note", note, 0);
        check("stop_busy", busy, 0);
        watch(30, aud, dn, fa, fd);
        check("stop_aud", aud, 0);
        check("stop_done", dn, 0);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        watch(5, aud, dn, fa, fd);
        check("startstop_aud", aud, 0);
        check("startstop_busy", busy, 0);

        // Reset mid-note
        pulse_start();
        watch(5, aud, dn, fa, fd);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_note", note, 0);
        check("rst_busy", busy, 0);

        // Full ROM with no marker; start re-asserted mid-song
        for (int i = 0; i < 8; i++) rom[i] = {5'd3, 2'd1, 3'd1};
        pulse_start();
        watch(40, aud, dn, fa, fd);
        aud_sum = aud; dn_sum = dn;
        start = 1'b1;
        watch(10, aud, dn, fa, fd);
        aud_sum += aud; dn_sum += dn;
        start = 1'b0;
        watch(50, aud, dn, fa, fd);
        aud_sum += aud; dn_sum += dn;
        check("full_aud", aud_sum, 64);
        check("full_done_cnt", dn_sum, 1);
        check("full_done_at", fd, 46);
        check("full_addr", rom_addr, 7);
        check("full_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Upstream driver for the buzzer tone generator. Steps through a song stored in an external synchronous ROM, one word per note. Drives the buzzer's note/pitch inputs for each note's duration, inserts a short silent articulation gap at the end of every note, and reports busy/done to the game/menu controller.

Parameters:
SIXTEENTH_CYCLES, 6_250_000, clocks per sixteenth note (120 BPM at 50 MHz); must be >= 1.
GAP_CYCLES, 500_000, silent clocks at the end of each note; must be < SIXTEENTH_CYCLES.
ADDR_W, 6, ROM address width; the song holds at most 2**ADDR_W words.

Ports:
clk  in  1  system clock, 50 MHz, rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  level-sampled request to play from ROM address 0; ignored while busy.
stop  in  1  abort playback; has priority over start.
loop_en  in  1  1 = restart at address 0 on end marker instead of finishing.
rom_addr  out  ADDR_W  ROM read address (registered).
rom_data  in  10  ROM word, valid one clock after rom_addr: [9:5] note code (0 = rest), [4:3] pitch (0 = silent), [2:0] dur in sixteenths (0 = end marker).
note  out  5  to buzzer note input.
pitch  out  2  to buzzer pitch input; 0 silences the buzzer.
busy  out  1  high from the cycle after start is accepted until playback ends.
done  out  1  one-cycle pulse on natural end only.
step_idx  out  ADDR_W  ROM address of the current or last step.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low on rst_n, as fixed above.
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - rom_addr, step_idx, note, pitch, busy, done and the duration counter all go to 0.
  - Reset mid-note silences the outputs on that edge.
- States: IDLE, FETCH, DECODE, PLAY, DONE.
- IDLE:
  - Outputs silent (note=0, pitch=0), busy=0.
  - start=1 and stop=0 at an edge: rom_addr<=0, busy<=1, go to FETCH.
- FETCH: one cycle while the ROM reads rom_addr. Outputs silent.
- DECODE: sample rom_data.
  - dur!=0: note<=data[9:5], pitch<=data[4:3], step_idx<=rom_addr, counter<=dur*SIXTEENTH_CYCLES-1, go to PLAY.
  - dur==0 with loop_en=1 and rom_addr!=0: rom_addr<=0, go to FETCH.
  - dur==0 otherwise (this includes a marker at address 0): go to DONE.
- PLAY:
  - Counter decrements once per clock.
  - When counter == GAP_CYCLES-1 at an edge, note<=0 and pitch<=0. The audible span is exactly dur*SIXTEENTH_CYCLES-GAP_CYCLES clocks.
  - When counter == 0: if rom_addr == 2**ADDR_W-1, go to DONE (the address never wraps). Otherwise rom_addr<=rom_addr+1 and go to FETCH.
- Timing:
  - Step period is dur*SIXTEENTH_CYCLES+2 clocks; FETCH and DECODE are silent.
  - The first note appears on the second edge after the edge that samples start.
- DONE: one cycle with done=1, busy=0, outputs silent, then IDLE.
- stop=1 at any edge outside reset:
  - Go to IDLE, note=0, pitch=0, busy=0, no done pulse; rom_addr is held.
  - start and stop asserted together in IDLE: remain in IDLE.
- start while busy: no effect.
- loop_en is sampled only in DECODE; changing it mid-note affects only the next end marker.
- A rest (note=0, pitch!=0) is timed like a note; the buzzer stays silent through it.
- Counter width must hold 7*SIXTEENTH_CYCLES-1 (26 bits at the defaults).

Test Plan:
All scenarios use SIXTEENTH_CYCLES=10, GAP_CYCLES=2, ADDR_W=3.
1. Reset then idle: hold rst_n=0 for 3 clocks, release, no start -> note=0, pitch=0, busy=0, done=0, rom_addr=0 indefinitely.
2. Single note: ROM[0]={6,1,2}, ROM[1]=end marker; pulse start at edge E0 -> note=6, pitch=1 from E2 for 18 clocks; then silent; done pulses once, 24 clocks after E0; busy=0 afterwards.
3. Sequence with rest: ROM={1,1,1},{0,1,3},{9,2,1},end -> audible spans of 8/0/8 clocks, step periods 12/32/12; step_idx goes 0, 1, 2.
4. Loop: ROM as in scenario 2 with loop_en=1 -> note 6 repeats every 24 clocks, done never pulses; drop loop_en -> done after the current pass.
5. Stop mid-note: stop=1 at clock 5 of PLAY -> silent on the next edge, busy=0, no done; start=1 and stop=1 together in IDLE -> stays IDLE.
6. Full ROM, no marker: all 8 words {3,1,1} -> 8 notes, then DONE after address 7, rom_addr never wraps to 0; asserting start during playback changes nothing.
